// File: rtl/snes_pkg.sv
// snes_pkg: shared state encoding, default parameters and bit-order constant for the SNES poller
package snes_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    LOW    = 3'd2,
    HI     = 3'd3,
    COMMIT = 3'd4
  } state_t;
  localparam int DEF_NUM_PADS     = 2;
  localparam int DEF_NUM_BITS     = 12;
  localparam int DEF_CLK_DIV      = 3;
  localparam int DEF_LATCH_CYCLES = 4;
  localparam int DEF_POLL_PERIOD  = 208333;
  localparam int DEF_ADDR_W       = 2;
  localparam bit FIRST_BIT_MSB    = 1'b1;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/snes_sync.sv
// snes_sync: parametrised-width 2-FF synchroniser for the asynchronous pad data lines
module snes_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  // two-stage capture; resets to the released (idle-high) line level
  always_ff @(posedge clk)
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/snes_poller.sv
// snes_poller: polls NUM_PADS SNES controllers in parallel and exposes button/press state on a read port
module snes_poller
  import snes_pkg::*;
#(
  parameter int NUM_PADS     = DEF_NUM_PADS,
  parameter int NUM_BITS     = DEF_NUM_BITS,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int POLL_PERIOD  = DEF_POLL_PERIOD,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                auto_en,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [NUM_BITS-1:0] rd_data,
  output logic [NUM_BITS-1:0] rd_press,
  output logic                busy,
  output logic                frame_done,
  input  logic [NUM_PADS-1:0] snes_data,
  output logic                snes_latch,
  output logic                snes_pulse
);
  localparam int CW = $clog2(max2(CLK_DIV, LATCH_CYCLES));
  localparam int TW = $clog2(POLL_PERIOD + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [4:0] bit_cnt;
  logic [TW-1:0] timer;
  logic pending, trig, last, sample, commit;
  logic latch_n, pulse_n, busy_n, done_n;
  logic [NUM_PADS-1:0] sync_q;
  logic [NUM_BITS-1:0] shift [NUM_PADS];
  logic [NUM_BITS-1:0] buttons [NUM_PADS];
  logic [NUM_BITS-1:0] press [NUM_PADS];
  logic [NUM_BITS-1:0] rd_data_n, rd_press_n;

  snes_sync #(.W(NUM_PADS)) u_sync (.clk(clk), .reset(reset), .d(snes_data), .q(sync_q));

  assign trig   = auto_en && timer == '0;
  assign last   = cnt == (state == LATCH ? CW'(LATCH_CYCLES - 1) : CW'(CLK_DIV - 1));
  assign sample = state == LOW && last;
  assign commit = state == COMMIT;

  // state register; outputs are registered from the next-state decode so they align with the state
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      snes_latch <= 1'b0;
      snes_pulse <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt;
      snes_latch <= latch_n;
      snes_pulse <= pulse_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end

  // next-state logic: latch, then alternating low/high shift phases, one commit cycle
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = (start || trig || pending) ? LATCH : IDLE;
      LATCH:   nxt = last ? LOW : LATCH;
      LOW:     nxt = !last ? LOW : (bit_cnt == 5'(NUM_BITS - 1)) ? COMMIT : HI;
      HI:      nxt = last ? LOW : HI;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // output decode of the upcoming state
  always_comb begin
    latch_n = nxt == LATCH;
    pulse_n = nxt == HI;
    busy_n  = nxt != IDLE;
    done_n  = nxt == COMMIT;
  end

  // phase cycle counter restarts on every state change; bit counter counts samples in a frame
  always_ff @(posedge clk)
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      cnt     <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      bit_cnt <= state == IDLE ? '0 : bit_cnt + 5'(sample);
    end

  // auto-poll timer; a trigger that lands mid-frame is remembered once and replayed from IDLE
  always_ff @(posedge clk)
    if (reset) begin
      timer   <= TW'(POLL_PERIOD - 1);
      pending <= 1'b0;
    end else begin
      if (auto_en) timer <= trig ? TW'(POLL_PERIOD - 1) : timer - 1'b1;
      pending <= auto_en && state != IDLE && (pending || trig);
    end

  // per-pad shift, button and sticky press registers; a read clears press but never drops a new edge
  always_ff @(posedge clk)
    if (reset) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        shift[p]   <= '0;
        buttons[p] <= '0;
        press[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (sample) shift[p] <= FIRST_BIT_MSB ? {shift[p][NUM_BITS-2:0], ~sync_q[p]} : {~sync_q[p], shift[p][NUM_BITS-1:1]};
        if (commit) buttons[p] <= shift[p];
        press[p] <= ((rd_en && rd_addr == ADDR_W'(p)) ? '0 : press[p]) | (commit ? shift[p] & ~buttons[p] : '0);
      end
    end

  // read mux; addresses with no pad behind them read as zero
  always_comb begin
    rd_data_n  = '0;
    rd_press_n = '0;
    for (int p = 0; p < NUM_PADS; p++)
      if (rd_addr == ADDR_W'(p)) begin
        rd_data_n  = buttons[p];
        rd_press_n = press[p];
      end
  end

  // read port registers hold between reads
  always_ff @(posedge clk)
    if (reset) begin
      rd_data  <= '0;
      rd_press <= '0;
    end else if (rd_en) begin
      rd_data  <= rd_data_n;
      rd_press <= rd_press_n;
    end
endmodule

// File: doc/snes_poller.md
Name: snes_poller

Overview:
Parametrised successor to the two-pad SNES controller interface. Polls NUM_PADS serial controllers in parallel and drives a shared latch/clock pair. Software can start a frame on demand, or the block can auto-poll at a fixed period. Samples are fully synchronous: there is no derived-clock or negedge logic. Per-pad button state and clear-on-read "newly pressed" flags are presented to the CPU peripheral bus alongside the 100us timer.

Parameters:
NUM_PADS, 2, number of controllers polled in parallel (1..4)
NUM_BITS, 12, serial bits captured per pad per frame (2..16)
CLK_DIV, 3, clk cycles per high or low half-period of snes_pulse (>=2)
LATCH_CYCLES, 4, clk cycles snes_latch is held high (>=3, i.e. >200ns at 12.5MHz)
POLL_PERIOD, 208333, clk cycles between auto-poll frames (about 60Hz at 12.5MHz)
ADDR_W, 2, width of rd_addr; must satisfy 2**ADDR_W >= NUM_PADS

Ports:
clk  in  1  system clock, 12.5MHz
reset  in  1  synchronous, active-high
start  in  1  one-cycle request for a single poll frame
auto_en  in  1  enables periodic polling every POLL_PERIOD cycles
rd_en  in  1  read strobe for the pad selected by rd_addr
rd_addr  in  ADDR_W  pad index
rd_data  out  NUM_BITS  button state, 1 = pressed
rd_press  out  NUM_BITS  buttons newly pressed since this pad's last read
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse when new data is committed
snes_data  in  NUM_PADS  serial data from each pad, active-low, asynchronous
snes_latch  out  1  latch pulse to all pads
snes_pulse  out  1  shift clock to all pads

Behaviour:
- Reset: every output is 0. State is IDLE. Button, press and shift registers are 0. The poll timer is loaded with POLL_PERIOD-1 and the pending flag is cleared. A reset mid-frame aborts the frame: snes_latch and snes_pulse are low after the next edge, and no commit occurs.
- snes_data passes through a 2-FF synchroniser per bit. Only the synchronised value is sampled.
- All outputs are registered. snes_latch is high exactly in LATCH, snes_pulse is high exactly in HI, and busy is high in every state except IDLE.
- FSM states: IDLE, LATCH, LOW, HI, COMMIT. A cycle counter (clog2 of max(CLK_DIV, LATCH_CYCLES) bits) and a bit counter (5 bits) drive the transitions.
  - IDLE -> LATCH when start is high, the auto timer expires, or pending=1.
  - LATCH: stays LATCH_CYCLES cycles, then -> LOW.
  - LOW: stays CLK_DIV cycles. On its last cycle it samples all pads: shift[p] <= {shift[p][NUM_BITS-2:0], ~sync[p]}, and bit_cnt increments. If bit_cnt reaches NUM_BITS it goes -> COMMIT, otherwise -> HI.
  - HI: stays CLK_DIV cycles, then -> LOW.
  - COMMIT: one cycle. For each pad, press[p] <= press[p] | (shift[p] & ~buttons[p]) and buttons[p] <= shift[p]. frame_done=1 this cycle. Then -> IDLE.
- Each frame produces NUM_BITS-1 pulses and NUM_BITS samples. The first bit captured lands in bit NUM_BITS-1.
- Frame length is LATCH_CYCLES + NUM_BITS*CLK_DIV + (NUM_BITS-1)*CLK_DIV + 1 cycles. With defaults this is 4+36+33+1 = 74 cycles from LATCH entry to the COMMIT cycle inclusive.
- Auto timer:
  - Free-runs down while auto_en=1. At 0 it reloads POLL_PERIOD-1 and raises a trigger.
  - Holds its value and clears pending while auto_en=0.
  - A trigger outside IDLE sets pending. Only one trigger is remembered.
  - start while busy is ignored and does not set pending.
- Read port, 1-cycle latency:
  - On rd_en, rd_data <= buttons[rd_addr], rd_press <= press[rd_addr], and press[rd_addr] is cleared.
  - When rd_addr >= NUM_PADS, both outputs are 0 and no state changes.
  - Outputs hold between reads.
- Simultaneous rd_en and COMMIT on the same pad:
  - rd_press returns the pre-commit press value.
  - press[p] becomes (shift & ~buttons) only, so new edges are not lost.
  - rd_data returns the pre-commit buttons.

Decomposition:
- Package snes_pkg holds:
  - state encoding: IDLE=0, LATCH=1, LOW=2, HI=3, COMMIT=4 (3 bits)
  - default parameter constants
  - the bit-order constant (first bit -> MSB)
- One sub-module, snes_sync, is a parametrised-width 2-FF synchroniser instantiated once at width NUM_PADS.
- Per-pad registers are generated arrays inside snes_poller.

Test Plan:
1. Defaults, pads model 12-bit 0xA5C (active-low on the wire), start pulse -> latch high 4 cycles, 11 pulses each 3 high/3 low, frame_done 74 cycles after LATCH entry (+2 synchroniser latency on data only); then rd_en addr 0 -> rd_data=0xA5C, rd_press=0xA5C.
2. Second frame with pad0=0xA5D -> rd_press=0x001 and rd_data=0xA5D; an immediate re-read gives rd_press=0x000.
3. auto_en=1, POLL_PERIOD overridden to 200 -> frames start every 200 cycles. Assert start mid-frame -> no extra frame and busy never drops early.
4. rd_en for pad1 in the same cycle as COMMIT, where pad1 goes 0x000->0x010 and prior press=0x100 -> rd_press=0x100, and the next read gives 0x010.
5. reset asserted at cycle 30 of a frame -> next cycle snes_latch=0, snes_pulse=0, busy=0, rd_data=0, and no frame_done.
6. NUM_PADS=4, NUM_BITS=16, CLK_DIV=2, distinct patterns per pad -> each read returns the right pattern; rd_addr beyond 3 is not applicable (ADDR_W=2); with NUM_PADS=3, rd_addr=3 -> 0.
